// File: rtl/sr_latch_driver_if.sv
// Command handshake between a requester and the SR latch driver.
// The requester uses the master side; the driver uses the slave side.
interface sr_latch_driver_if;
    logic cmd_valid;
    logic cmd_set;
    logic cmd_ready;
    logic done;
    logic err;
    logic q_state;

    modport master (
        output cmd_valid,
        output cmd_set,
        input  cmd_ready,
        input  done,
        input  err,
        input  q_state
    );

    modport slave (
        input  cmd_valid,
        input  cmd_set,
        output cmd_ready,
        output done,
        output err,
        output q_state
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives a cross-coupled NAND SR latch with timed active-low pulses, then
// verifies the latch through synchronized q/qbar readback.
module sr_latch_driver #(
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    sr_latch_driver_if.slave   cmd,
    output logic               sbar,
    output logic               rbar,
    input  logic               q_in,
    input  logic               qbar_in
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cmd_set_q;
    logic [1:0]       q_sync;
    logic [1:0]       qbar_sync;
    logic             readback_ok;

    // Two-flop synchronizers for the asynchronous latch readback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_sync    <= 2'b00;
            qbar_sync <= 2'b00;
        end else begin
            q_sync    <= {q_sync[0], q_in};
            qbar_sync <= {qbar_sync[0], qbar_in};
        end
    end

    assign readback_ok = (q_sync[1] == cmd_set_q) && (qbar_sync[1] == ~cmd_set_q);

    // Only one of sbar/rbar is ever loaded low, and only on entry to PULSE,
    // so the pair can never be 0 together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd_set_q     <= 1'b0;
            sbar          <= 1'b1;
            rbar          <= 1'b1;
            cmd.cmd_ready <= 1'b1;
            cmd.done      <= 1'b0;
            cmd.err       <= 1'b0;
            cmd.q_state   <= 1'b0;
        end else begin
            cmd.done <= 1'b0;
            cmd.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        state         <= PULSE;
                        cmd_set_q     <= cmd.cmd_set;
                        cnt           <= CNT_W'(PULSE_CYCLES - 1);
                        sbar          <= ~cmd.cmd_set;
                        rbar          <= cmd.cmd_set;
                        cmd.cmd_ready <= 1'b0;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state <= SETTLE;
                        sbar  <= 1'b1;
                        rbar  <= 1'b1;
                        cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    // done/err/q_state become visible in the CHECK cycle.
                    if (cnt == '0) begin
                        state    <= CHECK;
                        cmd.done <= 1'b1;
                        if (readback_ok) begin
                            cmd.q_state <= cmd_set_q;
                        end else begin
                            cmd.err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    state         <= IDLE;
                    cmd.cmd_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    sbar          <= 1'b1;
                    rbar          <= 1'b1;
                    cmd.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver driving a behavioural NAND latch.
module tb_sr_latch_driver;

    localparam int unsigned PULSE_CYCLES  = 4;
    localparam int unsigned SETTLE_CYCLES = 2;
    localparam int DONE_OFS = PULSE_CYCLES + SETTLE_CYCLES;
    localparam int BUSY     = PULSE_CYCLES + SETTLE_CYCLES + 1;

    typedef struct {
        int   due;
        logic err;
        logic q;
    } exp_t;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic reset  = 1'b0;
    logic sbar, rbar, q_in, qbar_in;

    logic lat_q      = 1'b0;
    logic latch_en   = 1'b1;
    logic force_q    = 1'b0;
    logic force_qbar = 1'b1;

    exp_t sb[$];
    exp_t e_new;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   busy      = 0;
    int   ps        = 0;
    logic exp_ready = 1'b1;
    logic exp_q     = 1'b0;
    logic pact      = 1'b0;
    logic pset      = 1'b0;
    logic es, er;

    sr_latch_driver_if cmd_if();

    sr_latch_driver #(
        .PULSE_CYCLES  (PULSE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd_if),
        .sbar    (sbar),
        .rbar    (rbar),
        .q_in    (q_in),
        .qbar_in (qbar_in)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // NAND latch: holds while both drives are inactive.
    always @(sbar or rbar) begin
        if (sbar === 1'b0 && rbar === 1'b1) lat_q = 1'b1;
        else if (sbar === 1'b1 && rbar === 1'b0) lat_q = 1'b0;
    end

    assign q_in    = latch_en ? lat_q  : force_q;
    assign qbar_in = latch_en ? ~lat_q : force_qbar;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: acceptance, ready window, pulse window, expected results.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_ready = 1'b1;
            busy      = 0;
            exp_q     = 1'b0;
            pact      = 1'b0;
            sb.delete();
        end else begin
            cyc++;
            if (exp_ready && cmd_if.cmd_valid) begin
                e_new.due = cyc + DONE_OFS;
                e_new.err = latch_en ? 1'b0 :
                            !(force_q == cmd_if.cmd_set && force_qbar == !cmd_if.cmd_set);
                e_new.q   = e_new.err ? exp_q : cmd_if.cmd_set;
                exp_q     = e_new.q;
                sb.push_back(e_new);
                pact      = 1'b1;
                pset      = cmd_if.cmd_set;
                ps        = cyc;
                exp_ready = 1'b0;
                busy      = BUSY;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) exp_ready = 1'b1;
            end
        end
    end

    // Per-cycle output checks and scoreboard pop on done.
    always @(negedge clk) begin
        es = !(pact && pset && cyc >= ps && cyc < ps + PULSE_CYCLES);
        er = !(pact && !pset && cyc >= ps && cyc < ps + PULSE_CYCLES);
        check_eq("sbar", sbar, es);
        check_eq("rbar", rbar, er);
        check_eq("sbar_or_rbar", sbar | rbar, 1);
        check_eq("cmd_ready", cmd_if.cmd_ready, exp_ready);
        if (cmd_if.done) begin
            if (sb.size() == 0) begin
                check_eq("done_spurious", cmd_if.done, 0);
            end else begin
                check_eq("done_cycle", cyc, sb[0].due);
                check_eq("err", cmd_if.err, sb[0].err);
                check_eq("q_state", cmd_if.q_state, sb[0].q);
                void'(sb.pop_front());
            end
        end else begin
            check_eq("err_without_done", cmd_if.err, 0);
            if (sb.size() != 0 && cyc >= sb[0].due) begin
                check_eq("done_missing", cmd_if.done, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic s);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready) break;
        end
        check_eq("ready_wait", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_set   = s;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_set   = ~s;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("drain", sb.size(), 0);
        check_eq("q_state_hold", cmd_if.q_state, exp_q);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_set   = 1'b0;
        #1 reset = 1'b1;
        #2;
        check_eq("rst_sbar", sbar, 1);
        check_eq("rst_rbar", rbar, 1);
        check_eq("rst_ready", cmd_if.cmd_ready, 1);
        check_eq("rst_done", cmd_if.done, 0);
        check_eq("rst_err", cmd_if.err, 0);
        check_eq("rst_q_state", cmd_if.q_state, 0);

        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        issue(1'b1); drain();
        issue(1'b0); drain();

        // Readback forced wrong: err with done, q_state unchanged.
        latch_en = 1'b0; force_q = 1'b0; force_qbar = 1'b1;
        issue(1'b1); drain();
        check_eq("q_state_after_err", cmd_if.q_state, 0);
        force_q = 1'b1; force_qbar = 1'b1;
        issue(1'b1); drain();
        latch_en = 1'b1;

        // Repeat of the current value still gets a full pulse and check.
        issue(1'b0); drain();
        issue(1'b0); drain();

        // cmd_valid held with toggling cmd_set while busy.
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_set   = 1'b1;
        repeat (26) begin
            @(negedge clk);
            cmd_if.cmd_set = ~cmd_if.cmd_set;
        end
        cmd_if.cmd_valid = 1'b0;
        drain();

        // Reset during the second pulse cycle.
        issue(1'b1);
        @(negedge clk);
        check_eq("pulse_before_reset", sbar, 0);
        #1 reset = 1'b1;
        #1;
        check_eq("abort_sbar", sbar, 1);
        check_eq("abort_rbar", rbar, 1);
        check_eq("abort_ready", cmd_if.cmd_ready, 1);
        check_eq("abort_done", cmd_if.done, 0);
        check_eq("abort_err", cmd_if.err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_q_state", cmd_if.q_state, 0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_set   = 1'b1;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check_eq("first_cmd_after_reset", sbar, 0);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, sets the number of cycles an active-low set or reset pulse is held (legal range 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 2, sets the number of both-inactive cycles between pulse end and readback check (legal range 2..255).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_set  input  1  command value: 1 = set latch (q=1), 0 = clear latch (q=0).
REQ-007 cmd_ready  output  1  driver can accept a command.
REQ-008 sbar  output  1  active-low set drive to the cross-coupled NAND latch.
REQ-009 rbar  output  1  active-low reset drive to the latch.
REQ-010 q_in  input  1  latch q readback, asynchronous to clk.
REQ-011 qbar_in  input  1  latch qbar readback, asynchronous to clk.
REQ-012 done  output  1  one-cycle pulse: command finished.
REQ-013 err  output  1  one-cycle pulse, coincident with done: readback mismatch.
REQ-014 q_state  output  1  last successfully verified latch value.

Function
REQ-015 All outputs SHALL be registered; sbar and rbar SHALL be glitch-free flop outputs.
REQ-016 States: IDLE, PULSE, SETTLE, CHECK.
REQ-017 IDLE: cmd_ready=1, sbar=1, rbar=1; command accepted on an edge where cmd_valid=1 and cmd_ready=1; cmd_set captured; next state PULSE.
REQ-018 PULSE: sbar=0 if captured cmd_set=1, else rbar=0; held exactly PULSE_CYCLES cycles; next state SETTLE.
REQ-019 sbar and rbar SHALL never be 0 in the same cycle, under any input sequence or reset.
REQ-020 SETTLE: sbar=1, rbar=1 for exactly SETTLE_CYCLES cycles; next state CHECK.
REQ-021 q_in and qbar_in SHALL each pass through a two-flop synchronizer; CHECK uses only synchronized values.
REQ-022 CHECK (one cycle): done=1; err=1 unless sync q_in==cmd_set and sync qbar_in==!cmd_set; on pass q_state <= cmd_set, on fail q_state unchanged; next state IDLE.
REQ-023 Latency: command accepted at edge k -> pulse visible cycles k+1..k+PULSE_CYCLES -> done high cycle k+PULSE_CYCLES+SETTLE_CYCLES+1.
REQ-024 cmd_ready=0 in PULSE, SETTLE, CHECK; cmd_valid during those states is ignored and not queued.
REQ-025 Back-to-back: earliest next acceptance is the edge ending the first IDLE cycle after CHECK.
REQ-026 A command equal to q_state SHALL still issue a full pulse and check (no short-circuit).
REQ-027 cmd_set is sampled only at acceptance; later changes have no effect.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force state IDLE, sbar=1, rbar=1, cmd_ready=1, done=0, err=0, q_state=0, synchronizers=0, counters=0.
REQ-029 Reset asserted mid-PULSE SHALL release the active pulse without waiting for clk and SHALL suppress done/err for the aborted command.
REQ-030 After reset deasserts, the first command is accepted on the first clk edge with cmd_valid=1.

Verification (PULSE_CYCLES=4, SETTLE_CYCLES=2, bench NAND latch model wired to sbar/rbar)
REQ-031 Assert reset, no clk -> sbar=1, rbar=1, cmd_ready=1, done=0, err=0, q_state=0.
REQ-032 cmd_valid=1, cmd_set=1 accepted at edge k -> sbar=0 cycles k+1..k+4, rbar=1 throughout, done=1 and err=0 in cycle k+7, q_state=1 thereafter.
REQ-033 Then cmd_set=0 command -> rbar=0 for exactly 4 cycles, done in cycle accept+7, err=0, q_state=0.
REQ-034 Latch model disconnected, q_in forced 0, qbar_in forced 1, set command -> done=1 and err=1 same cycle, q_state stays 0.
REQ-035 cmd_valid held 1 with toggling cmd_set during PULSE/SETTLE -> no extra pulses, cmd_ready=0, exactly one done per accepted command.
REQ-036 reset asserted in 2nd PULSE cycle -> sbar=1 before next clk edge, no done/err, IDLE after release; assertion sbar|rbar==1 checked every cycle in all scenarios.
